// File: rtl/debouncer_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, per-channel stability counter,
// debounced level plus registered one-cycle press/release strobes.
module debouncer_multi #(
   parameter int CHANNELS       = 4,
   parameter int CLK_FREQ_MHZ   = 50,
   parameter int GLITCH_TIME_NS = 100,
   parameter bit ACTIVE_LOW     = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CHANNELS-1:0] key_i,
   output logic [CHANNELS-1:0] key_state_o,
   output logic [CHANNELS-1:0] key_pressed_stb_o,
   output logic [CHANNELS-1:0] key_released_stb_o,
   output logic                any_pressed_stb_o
);

   localparam int WAIT_RAW   = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
   localparam int WAIT_TICKS = (WAIT_RAW < 1) ? 1 : WAIT_RAW;
   localparam int CNT_W      = (WAIT_TICKS < 2) ? 1 : $clog2(WAIT_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TICKS - 1);

   logic [CHANNELS-1:0] sync1_q, sync2_q, raw;
   logic [CHANNELS-1:0] state_q, state_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] release_q, release_d;
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];

   // Inverting after the synchroniser keeps "1 = pressed" everywhere downstream.
   assign raw = sync2_q ^ {CHANNELS{ACTIVE_LOW}};

   always_comb begin
      state_d   = state_q;
      press_d   = '0;
      release_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c] = '0;
         if (raw[c] != state_q[c]) begin
            if (cnt_q[c] == CNT_LAST) begin
               state_d[c]   = raw[c];
               press_d[c]   = raw[c];
               release_d[c] = ~raw[c];
            end else begin
               cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= {CHANNELS{ACTIVE_LOW}};
         sync2_q   <= {CHANNELS{ACTIVE_LOW}};
         state_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
      end else begin
         sync1_q   <= key_i;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign key_state_o        = state_q;
   assign key_pressed_stb_o  = press_q;
   assign key_released_stb_o = release_q;
   assign any_pressed_stb_o  = |press_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: default 4-channel instance, an active-low
// instance and a single-tick (WAIT_TICKS=1) instance.
module tb_debouncer_multi;

   logic       clk;
   logic       rst;
   logic [3:0] key;
   logic [3:0] state, press, rel;
   logic       any;
   logic [0:0] key_al, state_al, press_al, rel_al;
   logic       any_al;
   logic [0:0] key_w1, state_w1, press_w1, rel_w1;
   logic       any_w1;

   int total = 0;
   int bad   = 0;
   int press_cnt [4];
   int rel_cnt   [4];
   int al_press_cnt = 0;
   logic [3:0] exp_q [$];

   debouncer_multi dut (
      .clk_i(clk), .rst_i(rst), .key_i(key),
      .key_state_o(state), .key_pressed_stb_o(press),
      .key_released_stb_o(rel), .any_pressed_stb_o(any)
   );

   debouncer_multi #(.CHANNELS(1), .ACTIVE_LOW(1'b1)) dut_al (
      .clk_i(clk), .rst_i(rst), .key_i(key_al),
      .key_state_o(state_al), .key_pressed_stb_o(press_al),
      .key_released_stb_o(rel_al), .any_pressed_stb_o(any_al)
   );

   debouncer_multi #(.CHANNELS(1), .GLITCH_TIME_NS(20)) dut_w1 (
      .clk_i(clk), .rst_i(rst), .key_i(key_w1),
      .key_state_o(state_w1), .key_pressed_stb_o(press_w1),
      .key_released_stb_o(rel_w1), .any_pressed_stb_o(any_w1)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled just after each active edge.
   initial begin
      for (int c = 0; c < 4; c++) begin
         press_cnt[c] = 0;
         rel_cnt[c]   = 0;
      end
   end
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < 4; c++) begin
         if (press[c] === 1'b1) press_cnt[c] = press_cnt[c] + 1;
         if (rel[c] === 1'b1)   rel_cnt[c]   = rel_cnt[c] + 1;
      end
      if (press_al === 1'b1) al_press_cnt = al_press_cnt + 1;
   end

   // Driver tasks
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int base_p, base_r;
   logic [3:0] e;
   logic [3:0] bounce_rise [5];
   logic [3:0] bounce_fall [2];

   initial begin
      rst    = 1'b1;
      key    = '0;
      key_al = 1'b1;
      key_w1 = 1'b0;
      step(3);
      check("rst_state", 32'(state), 32'(0));
      check("rst_press", 32'(press), 32'(0));
      check("rst_rel",   32'(rel),   32'(0));
      check("rst_any",   32'(any),   32'(0));
      check("rst_al_state", 32'(state_al), 32'(0));
      rst = 1'b0;
      step(10);
      check("al_idle_state", 32'(state_al), 32'(0));
      check("al_idle_press", 32'(al_press_cnt), 32'(0));

      // Single press on channel 0: pulse exactly at n+6.
      key[0] = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back((i == 6) ? 4'b0001 : 4'b0000);
      while (exp_q.size() != 0) begin
         step(1);
         e = exp_q.pop_front();
         check("t1_press_seq", 32'(press), 32'(e));
      end
      check("t1_state", 32'(state), 32'(4'b0001));
      key[0] = 1'b0;
      step(10);
      check("t1_released", 32'(state), 32'(0));
      check("t1_rel_cnt", 32'(rel_cnt[0]), 32'(1));

      // Channel 1: 4-cycle pulse rejected, 5-cycle pulse accepted.
      base_p = press_cnt[1];
      key[1] = 1'b1;
      step(4);
      key[1] = 1'b0;
      step(12);
      check("t2_short_press", 32'(press_cnt[1] - base_p), 32'(0));
      check("t2_short_state", 32'(state[1]), 32'(0));
      base_r = rel_cnt[1];
      key[1] = 1'b1;
      step(5);
      key[1] = 1'b0;
      step(20);
      check("t2_long_press", 32'(press_cnt[1] - base_p), 32'(1));
      check("t2_long_rel",   32'(rel_cnt[1] - base_r), 32'(1));
      check("t2_long_state", 32'(state[1]), 32'(0));

      // Channel 2 bounce: 1,0,1,1,0 then held 1.
      bounce_rise = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
      base_p = press_cnt[2];
      base_r = rel_cnt[2];
      for (int i = 0; i < 5; i++) begin
         key = bounce_rise[i];
         step(1);
      end
      key[2] = 1'b1;
      step(6);
      check("t3_early", 32'(press_cnt[2] - base_p), 32'(0));
      step(1);
      check("t3_strobe", 32'(press), 32'(4'b0100));
      step(1);
      check("t3_state", 32'(state), 32'(4'b0100));
      bounce_fall = '{4'b0000, 4'b0100};
      for (int i = 0; i < 2; i++) begin
         key = bounce_fall[i];
         step(1);
      end
      key[2] = 1'b0;
      step(15);
      check("t3_press_once", 32'(press_cnt[2] - base_p), 32'(1));
      check("t3_rel_once",   32'(rel_cnt[2] - base_r), 32'(1));
      check("t3_state_off",  32'(state), 32'(0));

      // Channels 0 and 3 together.
      key = 4'b1001;
      step(6);
      check("t4_any_early", 32'(any), 32'(0));
      step(1);
      check("t4_press", 32'(press), 32'(4'b1001));
      check("t4_any",   32'(any),   32'(1));
      step(1);
      check("t4_any_off",   32'(any),   32'(0));
      check("t4_press_off", 32'(press), 32'(0));
      check("t4_state",     32'(state), 32'(4'b1001));

      // Reset mid-count on channel 1 with keys 0 and 3 held.
      key = 4'b1011;
      step(5);
      rst = 1'b1;
      step(1);
      check("t5_rst_state", 32'(state), 32'(0));
      check("t5_rst_press", 32'(press), 32'(0));
      check("t5_rst_rel",   32'(rel),   32'(0));
      step(2);
      rst = 1'b0;
      step(6);
      check("t5_early_state", 32'(state), 32'(0));
      check("t5_early_press", 32'(press), 32'(0));
      step(1);
      check("t5_press", 32'(press), 32'(4'b1011));
      check("t5_any",   32'(any),   32'(1));
      check("t5_state", 32'(state), 32'(4'b1011));

      // Active-low instance: press is key_al falling.
      key_al = 1'b0;
      step(6);
      check("t6_early", 32'(state_al), 32'(0));
      step(1);
      check("t6_press", 32'(press_al), 32'(1));
      step(1);
      check("t6_state",     32'(state_al), 32'(1));
      check("t6_press_off", 32'(press_al), 32'(0));

      // WAIT_TICKS=1 instance: accepted two edges after sampling.
      key_w1 = 1'b1;
      step(2);
      check("t7_early", 32'(state_w1), 32'(0));
      step(1);
      check("t7_press", 32'(press_w1), 32'(1));
      check("t7_state", 32'(state_w1), 32'(1));
      step(1);
      check("t7_press_off", 32'(press_w1), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
